// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin mux-select arbiter.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the arbiter driving the mux selects.
interface mux4_rr_arbiter_if #(
    parameter int CW = 8
);
    logic [3:0]    req;
    logic [3:0]    gnt;
    logic          s0;
    logic          s1;
    logic          valid;
    logic [CW-1:0] hold_cnt;

    modport master (output req, input gnt, s0, s1, valid, hold_cnt);
    modport slave  (input req, output gnt, s0, s1, valid, hold_cnt);
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request at or after start, with wrap.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic [1:0] idx,
    output logic       found
);
    logic [7:0] doubled;
    logic [3:0] rotated;
    logic [1:0] offset;

    // rotated[i] is request (start + i) mod 4, so bit 0 has highest priority.
    assign doubled = {req, req};
    assign rotated = doubled[start +: 4];

    always_comb begin
        offset = '0;
        for (int i = 3; i >= 0; i--) begin
            if (rotated[i]) offset = 2'(i);
        end
    end

    assign found = |rotated;
    assign idx   = start + offset;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with tenure limit, driving the 4:1 mux selects and a valid strobe.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CW       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_rr_arbiter_if.slave bus
);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        state, state_nx;
    logic [1:0]    ptr, ptr_nx;
    logic [1:0]    sel, sel_nx;
    logic [3:0]    gnt, gnt_nx;
    logic [CW-1:0] hold_cnt, hold_nx;

    logic [1:0]    start;
    logic [1:0]    pick_idx;
    logic          pick_found;
    logic          others;
    logic          expired;
    logic          release_now;

    // While granted, the search starts just past the owner so the owner comes last.
    assign start = (state == ST_GRANT) ? sel + 2'd1 : ptr;

    rr_pick4 u_pick (
        .req   (bus.req),
        .start (start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign others      = |(bus.req & ~gnt);
    assign expired     = (hold_cnt == HOLD_LAST);
    assign release_now = !bus.req[sel] || (expired && others);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        gnt_nx   = gnt;
        hold_nx  = hold_cnt;
        unique case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nx = ST_GRANT;
                    sel_nx   = pick_idx;
                    gnt_nx   = onehot4(pick_idx);
                    hold_nx  = '0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    ptr_nx  = sel + 2'd1;
                    hold_nx = '0;
                    if (pick_found) begin
                        sel_nx = pick_idx;
                        gnt_nx = onehot4(pick_idx);
                    end else begin
                        state_nx = ST_IDLE;
                        gnt_nx   = '0;
                    end
                end else if (!expired) begin
                    hold_nx = hold_cnt + CW'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel      <= SEL_A;
            gnt      <= '0;
            hold_cnt <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state    <= state_nx;
            ptr      <= ptr_nx;
            sel      <= sel_nx;
            gnt      <= gnt_nx;
            hold_cnt <= hold_nx;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.s1       = sel[1];
    assign bus.s0       = sel[0];
    assign bus.valid    = (state == ST_GRANT);
    assign bus.hold_cnt = hold_cnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, and random traffic vs a reference model.
module tb_mux4_rr_arbiter;
    localparam int MAX_HOLD = 4;
    localparam int CW       = 8;
    localparam int NVEC     = 14;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        int         hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Reference model state, kept as plain integers.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;
    int m_sel;

    vec_t tbl [NVEC];

    mux4_rr_arbiter_if #(.CW(CW)) bus ();

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic v, input int h);
        check({tag, ".gnt"},   32'(bus.gnt), 32'(g));
        check({tag, ".sel"},   32'({bus.s1, bus.s0}), 32'(s));
        check({tag, ".valid"}, 32'(bus.valid), 32'(v));
        check({tag, ".hold"},  32'(bus.hold_cnt), h);
    endtask

    task automatic step(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = 4'b0000;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 4'b0000, 2'b00, 1'b0, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_sel   = 0;
    endtask

    function automatic int search(input logic [3:0] r, input int from);
        for (int k = 0; k < 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r);
        int nxt;
        if (!m_busy) begin
            nxt = search(r, m_ptr);
            if (nxt >= 0) begin
                m_busy  = 1'b1;
                m_owner = nxt;
                m_sel   = nxt;
                m_cnt   = 0;
            end
        end else begin
            bit rival;
            rival = (r & ~(4'b0001 << m_owner)) != 4'b0000;
            if (!r[m_owner] || (m_cnt == MAX_HOLD - 1 && rival)) begin
                m_ptr = (m_owner + 1) % 4;
                m_cnt = 0;
                nxt   = search(r, m_ptr);
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_sel   = nxt;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
        end
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] exp_g;

        tbl[0]  = '{4'b0010, 4'b0010, 2'b01, 1'b1, 0};
        tbl[1]  = '{4'b0000, 4'b0000, 2'b01, 1'b0, 0};
        tbl[2]  = '{4'b1111, 4'b0100, 2'b10, 1'b1, 0};
        tbl[3]  = '{4'b1111, 4'b0100, 2'b10, 1'b1, 1};
        tbl[4]  = '{4'b1011, 4'b1000, 2'b11, 1'b1, 0};
        tbl[5]  = '{4'b1001, 4'b1000, 2'b11, 1'b1, 1};
        tbl[6]  = '{4'b1001, 4'b1000, 2'b11, 1'b1, 2};
        tbl[7]  = '{4'b1001, 4'b1000, 2'b11, 1'b1, 3};
        tbl[8]  = '{4'b1001, 4'b0001, 2'b00, 1'b1, 0};
        tbl[9]  = '{4'b0001, 4'b0001, 2'b00, 1'b1, 1};
        tbl[10] = '{4'b0110, 4'b0010, 2'b01, 1'b1, 0};
        tbl[11] = '{4'b0000, 4'b0000, 2'b01, 1'b0, 0};
        tbl[12] = '{4'b0001, 4'b0001, 2'b00, 1'b1, 0};
        tbl[13] = '{4'b0000, 4'b0000, 2'b00, 1'b0, 0};

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].req);
            check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].hold);
        end

        // All four requesting: fixed tenures of MAX_HOLD cycles in order 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            int own;
            step(4'b1111);
            own = (k / MAX_HOLD) % 4;
            check_out($sformatf("all4_c%0d", k), 4'(1 << own), 2'(own), 1'b1, k % MAX_HOLD);
        end

        // Lone requester keeps the grant; counter saturates.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(4'b0100);
            check_out($sformatf("lone_c%0d", k), 4'b0100, 2'b10, 1'b1,
                      (k < MAX_HOLD - 1) ? k : MAX_HOLD - 1);
        end

        // Early release hands straight off to the waiting requester.
        do_reset();
        step(4'b0001);
        step(4'b0001);
        check_out("early_pre", 4'b0001, 2'b00, 1'b1, 1);
        step(4'b1000);
        check_out("early_hand", 4'b1000, 2'b11, 1'b1, 0);

        // Asynchronous reset in the middle of a tenure.
        do_reset();
        step(4'b0100);
        step(4'b0100);
        step(4'b0100);
        check_out("async_pre", 4'b0100, 2'b10, 1'b1, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_out("async_now", 4'b0000, 2'b00, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0100);
        check_out("async_regrant", 4'b0100, 2'b10, 1'b1, 0);

        // Random traffic against the reference model.
        do_reset();
        r = 4'b0000;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r);
            model_step(r);
            exp_g = m_busy ? 4'(1 << m_owner) : 4'b0000;
            check_out($sformatf("rand_c%0d", k), exp_g, 2'(m_sel), m_busy, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
